// File: rtl/ps2_mouse_init_sequencer_if.sv
// Byte-level link between the mouse init sequencer and ps2_controller.
// The sequencer is the master: it issues command bytes and consumes
// received bytes; the controller side (or a bench) is the slave.
interface ps2_mouse_init_sequencer_if;
   logic       cmd_send;
   logic [7:0] cmd_byte;
   logic [7:0] rx_data;
   logic       rx_strobe;
   logic       rx_parity_ok;

   modport master (
      output cmd_send,
      output cmd_byte,
      input  rx_data,
      input  rx_strobe,
      input  rx_parity_ok
   );

   modport slave (
      input  cmd_send,
      input  cmd_byte,
      output rx_data,
      output rx_strobe,
      output rx_parity_ok
   );
endinterface

// File: rtl/ps2_mouse_init_sequencer.sv
// PS/2 mouse bring-up sequencer.
// After reset (or a start pulse) it sends FF (reset), expects FA/AA/00,
// then sends F4 (enable streaming) and expects FA. Any bad answer, parity
// error or response timeout burns one attempt; after MAX_RETRIES extra
// attempts it parks in FAIL. Once streaming, bytes are aligned into
// 3-byte packets using the always-one bit 3 of the status byte.
module ps2_mouse_init_sequencer #(
   parameter int RESP_TIMEOUT = 50_000_000,
   parameter int GAP_TIMEOUT  = 100_000,
   parameter int MAX_RETRIES  = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   ps2_mouse_init_sequencer_if.master        ctrl,
   output logic                              init_done,
   output logic                              init_error,
   output logic [1:0]                        retry_count,
   output logic                              pkt_valid,
   output logic [7:0]                        byte1,
   output logic [7:0]                        byte2,
   output logic [7:0]                        byte3,
   output logic [3:0]                        state_dbg
);

   // Timers count 0..LIMIT-1, so LIMIT cycles elapse before they fire.
   localparam int RESP_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam int GAP_W  = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
   localparam logic [RESP_W-1:0] RESP_LAST   = RESP_W'(RESP_TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(GAP_TIMEOUT - 1);
   localparam logic [1:0]        RETRY_LIMIT = 2'(MAX_RETRIES);

   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_RESEND = 8'hFE;
   localparam logic [7:0] RSP_BAT    = 8'hAA;
   localparam logic [7:0] RSP_ID     = 8'h00;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      SEND_RST  = 4'd1,
      WAIT_ACK1 = 4'd2,
      WAIT_BAT  = 4'd3,
      WAIT_ID   = 4'd4,
      SEND_EN   = 4'd5,
      WAIT_ACK2 = 4'd6,
      STREAM    = 4'd7,
      FAIL      = 4'd8
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [RESP_W-1:0] resp_timer;
   logic [RESP_W-1:0] resp_timer_next;
   logic [GAP_W-1:0]  gap_timer;
   logic [GAP_W-1:0]  gap_timer_next;
   logic [1:0]        retry_next;
   logic [1:0]        fe_count;
   logic [1:0]        fe_next;
   logic [1:0]        idx;
   logic [1:0]        idx_next;
   logic [7:0]        hold1;
   logic [7:0]        hold1_next;
   logic [7:0]        hold2;
   logic [7:0]        hold2_next;
   logic              aa_seen;
   logic              aa_next;
   logic [7:0]        cmd_byte_q;
   logic [7:0]        cmd_byte_next;
   logic [7:0]        byte1_next;
   logic [7:0]        byte2_next;
   logic [7:0]        byte3_next;
   logic              pkt_next;
   logic              attempt_failed;

   logic rx_valid;
   logic rx_bad;
   logic resp_hit;
   logic gap_hit;
   logic in_wait;

   assign rx_valid = ctrl.rx_strobe && ctrl.rx_parity_ok;
   assign rx_bad   = ctrl.rx_strobe && !ctrl.rx_parity_ok;
   assign resp_hit = (resp_timer == RESP_LAST);
   assign gap_hit  = (gap_timer == GAP_LAST);
   assign in_wait  = (state == WAIT_ACK1) || (state == WAIT_BAT) ||
                     (state == WAIT_ID)   || (state == WAIT_ACK2);

   assign ctrl.cmd_send = (state == SEND_RST) || (state == SEND_EN);
   assign ctrl.cmd_byte = cmd_byte_q;
   assign init_done     = (state == STREAM);
   assign init_error    = (state == FAIL);
   assign state_dbg     = state;

   // Next-state, timer, retry and packet-alignment decisions for one cycle.
   always_comb begin
      state_next      = state;
      resp_timer_next = '0;
      gap_timer_next  = '0;
      retry_next      = retry_count;
      fe_next         = fe_count;
      idx_next        = idx;
      hold1_next      = hold1;
      hold2_next      = hold2;
      aa_next         = aa_seen;
      cmd_byte_next   = cmd_byte_q;
      byte1_next      = byte1;
      byte2_next      = byte2;
      byte3_next      = byte3;
      pkt_next        = 1'b0;
      attempt_failed  = 1'b0;

      if (in_wait) begin
         resp_timer_next = resp_hit ? resp_timer : resp_timer + RESP_W'(1);
      end

      case (state)
         IDLE: begin
            state_next = SEND_RST;
         end

         SEND_RST: begin
            state_next = WAIT_ACK1;
         end

         WAIT_ACK1: begin
            if (rx_bad) begin
               attempt_failed = 1'b1;
            end else if (rx_valid) begin
               if (ctrl.rx_data == RSP_ACK) begin
                  fe_next    = 2'd0;
                  state_next = WAIT_BAT;
               end else if (ctrl.rx_data == RSP_RESEND) begin
                  if (fe_count == 2'd2) begin
                     attempt_failed = 1'b1;
                  end else begin
                     fe_next    = fe_count + 2'd1;
                     state_next = SEND_RST;
                  end
               end else begin
                  attempt_failed = 1'b1;
               end
            end else if (resp_hit) begin
               attempt_failed = 1'b1;
            end
         end

         WAIT_BAT: begin
            if (rx_bad) begin
               attempt_failed = 1'b1;
            end else if (rx_valid) begin
               if (ctrl.rx_data == RSP_BAT) begin
                  state_next = WAIT_ID;
               end else begin
                  attempt_failed = 1'b1;
               end
            end else if (resp_hit) begin
               attempt_failed = 1'b1;
            end
         end

         WAIT_ID: begin
            if (rx_bad) begin
               attempt_failed = 1'b1;
            end else if (rx_valid) begin
               if (ctrl.rx_data == RSP_ID) begin
                  state_next = SEND_EN;
               end else begin
                  attempt_failed = 1'b1;
               end
            end else if (resp_hit) begin
               attempt_failed = 1'b1;
            end
         end

         SEND_EN: begin
            state_next = WAIT_ACK2;
         end

         WAIT_ACK2: begin
            if (rx_bad) begin
               attempt_failed = 1'b1;
            end else if (rx_valid) begin
               if (ctrl.rx_data == RSP_ACK) begin
                  fe_next    = 2'd0;
                  state_next = STREAM;
               end else if (ctrl.rx_data == RSP_RESEND) begin
                  if (fe_count == 2'd2) begin
                     attempt_failed = 1'b1;
                  end else begin
                     fe_next    = fe_count + 2'd1;
                     state_next = SEND_EN;
                  end
               end else begin
                  attempt_failed = 1'b1;
               end
            end else if (resp_hit) begin
               attempt_failed = 1'b1;
            end
         end

         STREAM: begin
            if (rx_bad) begin
               idx_next = 2'd0;
               aa_next  = 1'b0;
            end else if (rx_valid) begin
               aa_next = (ctrl.rx_data == RSP_BAT);
               if (aa_seen && (ctrl.rx_data == RSP_ID)) begin
                  state_next = SEND_EN;
               end else begin
                  case (idx)
                     2'd0: begin
                        if (ctrl.rx_data[3]) begin
                           hold1_next = ctrl.rx_data;
                           idx_next   = 2'd1;
                        end
                     end
                     2'd1: begin
                        hold2_next = ctrl.rx_data;
                        idx_next   = 2'd2;
                     end
                     default: begin
                        byte1_next = hold1;
                        byte2_next = hold2;
                        byte3_next = ctrl.rx_data;
                        pkt_next   = 1'b1;
                        idx_next   = 2'd0;
                     end
                  endcase
               end
            end else if (idx != 2'd0) begin
               if (gap_hit) begin
                  idx_next = 2'd0;
               end else begin
                  gap_timer_next = gap_timer + GAP_W'(1);
               end
            end
         end

         FAIL: begin
            state_next = FAIL;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      if (attempt_failed) begin
         fe_next = 2'd0;
         if (retry_count < RETRY_LIMIT) begin
            retry_next = retry_count + 2'd1;
            state_next = SEND_RST;
         end else begin
            state_next = FAIL;
         end
      end

      // start aborts everything, but the last delivered packet stays visible
      if (start) begin
         state_next = IDLE;
         retry_next = 2'd0;
         fe_next    = 2'd0;
         pkt_next   = 1'b0;
         byte1_next = byte1;
         byte2_next = byte2;
         byte3_next = byte3;
      end

      if (state_next != STREAM) begin
         idx_next       = 2'd0;
         aa_next        = 1'b0;
         gap_timer_next = '0;
      end

      if (state_next != state) begin
         resp_timer_next = '0;
      end

      if (state_next == SEND_RST) begin
         cmd_byte_next = CMD_RESET;
      end else if (state_next == SEND_EN) begin
         cmd_byte_next = CMD_ENABLE;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         resp_timer  <= '0;
         gap_timer   <= '0;
         retry_count <= 2'd0;
         fe_count    <= 2'd0;
         idx         <= 2'd0;
         hold1       <= 8'h00;
         hold2       <= 8'h00;
         aa_seen     <= 1'b0;
         cmd_byte_q  <= 8'h00;
         byte1       <= 8'h00;
         byte2       <= 8'h00;
         byte3       <= 8'h00;
         pkt_valid   <= 1'b0;
      end else begin
         state       <= state_next;
         resp_timer  <= resp_timer_next;
         gap_timer   <= gap_timer_next;
         retry_count <= retry_next;
         fe_count    <= fe_next;
         idx         <= idx_next;
         hold1       <= hold1_next;
         hold2       <= hold2_next;
         aa_seen     <= aa_next;
         cmd_byte_q  <= cmd_byte_next;
         byte1       <= byte1_next;
         byte2       <= byte2_next;
         byte3       <= byte3_next;
         pkt_valid   <= pkt_next;
      end
   end

endmodule
